// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, bus FSM states, CLAIM layout.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package irq_ctrl_pkg;

    // Word offsets decoded from addr_i[4:2]
    localparam logic [2:0] OFS_RAW     = 3'd0;
    localparam logic [2:0] OFS_PENDING = 3'd1;
    localparam logic [2:0] OFS_MASK    = 3'd2;
    localparam logic [2:0] OFS_EDGE    = 3'd3;
    localparam logic [2:0] OFS_CLAIM   = 3'd4;

    // Only full-word writes modify registers
    localparam logic [1:0] SEL_WORD = 2'b11;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_t;

    // CLAIM read layout: valid flag in bit 31, source index in bits 4:0
    typedef struct packed {
        logic        vld;
        logic [25:0] rsvd;
        logic [4:0]  idx;
    } claim_t;

    // Bits at or above n_src are never implemented
    function automatic logic [31:0] src_mask(input int n_src);
        if (n_src >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << n_src) - 32'd1;
    endfunction

    // Lowest set bit wins; all-zero vector yields an all-zero claim word
    function automatic claim_t claim_encode(input logic [31:0] vec);
        claim_t c;
        c = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                c.vld = 1'b1;
                c.idx = 5'(i);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// System-bus slave port of the interrupt controller (word-addressed register access).
// Latency: request seen in IDLE is acknowledged on the following cycle.
// Backpressure: master holds rd_i/we_i until ack_o; ack_o lasts exactly one cycle.
interface irq_ctrl_if;

    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic [1:0]  sel_i;
    logic        rd_i;
    logic        we_i;
    logic        ack_o;

    modport master (
        output addr_i,
        output data_i,
        output sel_i,
        output rd_i,
        output we_i,
        input  data_o,
        input  ack_o
    );

    modport slave (
        input  addr_i,
        input  data_i,
        input  sel_i,
        input  rd_i,
        input  we_i,
        output data_o,
        output ack_o
    );

endinterface

// File: rtl/irq_ctrl_sync.sv
// One interrupt source: optional 2-flop synchroniser plus a history flop for rise detection.
// Latency: level valid 2 cycles after src with SYNC_EN=1, combinational with SYNC_EN=0.
// Backpressure: none; samples every cycle.
module irq_ctrl_sync #(
    parameter bit SYNC_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic src,
    output logic level,
    output logic rise
);

    logic prev_q;

    generate
        if (SYNC_EN) begin : g_sync
            logic meta_q;
            logic sync_q;

            // Two-stage synchroniser for a source outside the clk domain
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_q <= 1'b0;
                    sync_q <= 1'b0;
                end else begin
                    meta_q <= src;
                    sync_q <= meta_q;
                end
            end

            assign level = sync_q;
        end else begin : g_bypass
            assign level = src;
        end
    endgenerate

    // Previous synchronised level, used to spot a 0->1 transition
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign rise = level & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches edge/level requests into PENDING, masks them, drives cpu irq vector.
// Latency: src_i rise -> irq_o in 4 cycles (SYNC_EN=1) or 2 (SYNC_EN=0); bus ack 1 cycle after request.
// Backpressure: bus master holds request until the one-cycle ack; at most one ack every two cycles.
module irq_ctrl #(
    parameter int N_SRC   = 32,
    parameter bit SYNC_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_i,
    output logic [31:0]      irq_o,
    irq_ctrl_if.slave        bus
);

    import irq_ctrl_pkg::*;

    localparam logic [31:0] SRC_MASK = src_mask(N_SRC);

    logic [31:0] level_vec;
    logic [31:0] rise_vec;
    logic [31:0] pending_q;
    logic [31:0] pending_nxt;
    logic [31:0] mask_q;
    logic [31:0] edge_q;
    logic [31:0] w1c_vec;
    logic [31:0] rd_mux;
    logic [31:0] data_q;
    logic [2:0]  ofs;
    claim_t      claim;

    bus_state_t  state_q;
    bus_state_t  state_nxt;
    logic        ack;
    logic        wr_commit;
    logic        rd_capture;

    // Address bits outside the register window are don't-care
    logic        unused_addr;
    assign unused_addr = &{1'b0, bus.addr_i[31:5], bus.addr_i[1:0]};

    // ------------------------------------------------------------------
    // Source conditioning
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < N_SRC; i++) begin : g_src
            irq_ctrl_sync #(
                .SYNC_EN (SYNC_EN)
            ) u_sync (
                .clk   (clk),
                .rst   (rst),
                .src   (src_i[i]),
                .level (level_vec[i]),
                .rise  (rise_vec[i])
            );
        end
        if (N_SRC < 32) begin : g_pad
            assign level_vec[31:N_SRC] = '0;
            assign rise_vec[31:N_SRC]  = '0;
        end
    endgenerate

    assign ofs = bus.addr_i[4:2];

    // ------------------------------------------------------------------
    // Bus handshake FSM
    // ------------------------------------------------------------------

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BUS_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state and per-transaction strobes; a combined rd+we is a write
    always_comb begin
        state_nxt  = state_q;
        ack        = 1'b0;
        wr_commit  = 1'b0;
        rd_capture = 1'b0;
        case (state_q)
            BUS_IDLE: begin
                if (bus.rd_i || bus.we_i) begin
                    state_nxt  = BUS_ACK;
                    wr_commit  = bus.we_i && (bus.sel_i == SEL_WORD);
                    rd_capture = bus.rd_i && !bus.we_i;
                end
            end
            BUS_ACK: begin
                state_nxt = BUS_IDLE;
                ack       = 1'b1;
            end
            default: begin
                state_nxt = BUS_IDLE;
            end
        endcase
    end

    assign bus.ack_o  = ack;
    assign bus.data_o = data_q;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------

    // Highest-priority enabled request for software
    always_comb begin
        claim = claim_encode(pending_q & mask_q);
    end

    // Read data selection; unmapped offsets read as zero
    always_comb begin
        rd_mux = '0;
        case (ofs)
            OFS_RAW:     rd_mux = level_vec;
            OFS_PENDING: rd_mux = pending_q;
            OFS_MASK:    rd_mux = mask_q;
            OFS_EDGE:    rd_mux = edge_q;
            OFS_CLAIM:   rd_mux = claim;
            default:     rd_mux = '0;
        endcase
    end

    // PENDING update: edge bits set on rise and clear on W1C (set wins), level bits follow the source
    always_comb begin
        w1c_vec = '0;
        if (wr_commit && (ofs == OFS_PENDING)) begin
            w1c_vec = bus.data_i & SRC_MASK;
        end
        pending_nxt = '0;
        for (int i = 0; i < 32; i++) begin
            if (edge_q[i]) begin
                pending_nxt[i] = rise_vec[i] | (pending_q[i] & ~w1c_vec[i]);
            end else begin
                pending_nxt[i] = level_vec[i];
            end
        end
        pending_nxt = pending_nxt & SRC_MASK;
    end

    // Control registers, pending state, registered irq vector and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            mask_q    <= '0;
            edge_q    <= '0;
            irq_o     <= '0;
            data_q    <= '0;
        end else begin
            if (wr_commit && (ofs == OFS_MASK)) begin
                mask_q <= bus.data_i & SRC_MASK;
            end
            if (wr_commit && (ofs == OFS_EDGE)) begin
                edge_q <= bus.data_i & SRC_MASK;
            end
            pending_q <= pending_nxt;
            irq_o     <= pending_q & mask_q;
            data_q    <= rd_capture ? rd_mux : 32'd0;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: edge/level latching, W1C, CLAIM priority, bus handshake, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] src;
    logic [31:0] irq;
    logic [31:0] rdat;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    irq_ctrl_if bus ();

    irq_ctrl #(
        .N_SRC   (32),
        .SYNC_EN (1'b1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .src_i (src),
        .irq_o (irq),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write starts immediately; commit happens on the next clock edge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sel, input logic also_rd);
        bus.addr_i = a;
        bus.data_i = d;
        bus.sel_i  = sel;
        bus.we_i   = 1'b1;
        bus.rd_i   = also_rd;
        tick();
        check("wr_ack", {31'b0, bus.ack_o}, 32'd1);
        check("wr_data", bus.data_o, 32'd0);
        bus.we_i = 1'b0;
        bus.rd_i = 1'b0;
        tick();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.addr_i = a;
        bus.sel_i  = 2'b11;
        bus.rd_i   = 1'b1;
        tick();
        check("rd_ack", {31'b0, bus.ack_o}, 32'd1);
        d = bus.data_o;
        bus.rd_i = 1'b0;
        tick();
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    initial begin
        rst        = 1'b1;
        src        = '0;
        bus.addr_i = '0;
        bus.data_i = '0;
        bus.sel_i  = 2'b11;
        bus.rd_i   = 1'b0;
        bus.we_i   = 1'b0;
        tick();
        tick();
        check("rst_irq", irq, 32'd0);
        check("rst_ack", {31'b0, bus.ack_o}, 32'd0);
        check("rst_data", bus.data_o, 32'd0);
        rst = 1'b0;
        tick();
        rd_check("rst_pending", 32'h04, 32'd0);
        rd_check("rst_mask", 32'h08, 32'd0);
        rd_check("rst_edge", 32'h0C, 32'd0);
        rd_check("rst_claim", 32'h10, 32'd0);

        // 1: single-cycle pulse on an edge-type source
        bus_write(32'h08, 32'h4, 2'b11, 1'b0);
        bus_write(32'h0C, 32'h4, 2'b11, 1'b0);
        src = 32'h4;
        tick();
        src = 32'h0;
        tick();
        tick();
        check("t1_irq_early", irq, 32'd0);
        tick();
        check("t1_irq_lat4", irq, 32'h4);
        rd_check("t1_claim", 32'h10, 32'h8000_0002);
        bus_write(32'h04, 32'h4, 2'b11, 1'b0);
        check("t1_irq_w1c", irq, 32'd0);
        rd_check("t1_pending", 32'h04, 32'd0);

        // 2: level source follows the line, ignores W1C
        src = 32'h20;
        bus_write(32'h08, 32'h20, 2'b11, 1'b0);
        tick();
        tick();
        tick();
        check("t2_irq_level", irq, 32'h20);
        rd_check("t2_raw", 32'h00, 32'h20);
        bus_write(32'h04, 32'h20, 2'b11, 1'b0);
        check("t2_irq_after_w1c", irq, 32'h20);
        rd_check("t2_pending", 32'h04, 32'h20);
        src = 32'h0;
        tick();
        tick();
        tick();
        check("t2_irq_hold", irq, 32'h20);
        tick();
        check("t2_irq_drop", irq, 32'd0);

        // 3: rise and W1C land on the same edge -> set wins
        bus_write(32'h08, 32'h8, 2'b11, 1'b0);
        bus_write(32'h0C, 32'hC, 2'b11, 1'b0);
        src = 32'h8;
        tick();
        tick();
        bus_write(32'h04, 32'h8, 2'b11, 1'b0);
        src = 32'h0;
        check("t3_irq", irq, 32'h8);
        rd_check("t3_pending", 32'h04, 32'h8);
        bus_write(32'h04, 32'h8, 2'b11, 1'b0);
        rd_check("t3_pending_clr", 32'h04, 32'd0);

        // 4: CLAIM priority and masking
        bus_write(32'h0C, 32'hE, 2'b11, 1'b0);
        src = 32'hA;
        tick();
        src = 32'h0;
        tick();
        tick();
        tick();
        check("t4_irq", irq, 32'h8);
        rd_check("t4_pending", 32'h04, 32'hA);
        rd_check("t4_claim3", 32'h10, 32'h8000_0003);
        bus_write(32'h08, 32'h0, 2'b11, 1'b0);
        check("t4_irq_masked", irq, 32'd0);
        rd_check("t4_claim_none", 32'h10, 32'd0);
        bus_write(32'h08, 32'hA, 2'b11, 1'b0);
        check("t4_irq_both", irq, 32'hA);
        rd_check("t4_claim1", 32'h10, 32'h8000_0001);
        bus_write(32'h04, 32'hA, 2'b11, 1'b0);
        check("t4_irq_clr", irq, 32'd0);

        // 5: bus corner cases
        bus_write(32'h08, 32'hFF, 2'b01, 1'b0);
        rd_check("t5_mask_sel", 32'h08, 32'hA);
        rd_check("t5_unmapped", 32'h18, 32'd0);
        bus_write(32'h14, 32'hFF, 2'b11, 1'b0);
        rd_check("t5_edge_keep", 32'h0C, 32'hE);
        bus_write(32'h08, 32'h10, 2'b11, 1'b1);
        rd_check("t5_mask_rdwe", 32'h08, 32'h10);
        bus.addr_i = 32'h08;
        bus.rd_i   = 1'b1;
        check("t5_hold_ack0", {31'b0, bus.ack_o}, 32'd0);
        tick();
        check("t5_hold_ack1", {31'b0, bus.ack_o}, 32'd1);
        check("t5_hold_data1", bus.data_o, 32'h10);
        tick();
        check("t5_hold_ack2", {31'b0, bus.ack_o}, 32'd0);
        check("t5_hold_data2", bus.data_o, 32'd0);
        tick();
        check("t5_hold_ack3", {31'b0, bus.ack_o}, 32'd1);
        bus.rd_i = 1'b0;
        tick();

        // 6: reset while a write is being acknowledged
        bus.addr_i = 32'h08;
        bus.data_i = 32'h55;
        bus.sel_i  = 2'b11;
        bus.we_i   = 1'b1;
        tick();
        check("t6_ack_before", {31'b0, bus.ack_o}, 32'd1);
        rst = 1'b1;
        tick();
        check("t6_ack_rst", {31'b0, bus.ack_o}, 32'd0);
        check("t6_data_rst", bus.data_o, 32'd0);
        check("t6_irq_rst", irq, 32'd0);
        rst      = 1'b0;
        bus.we_i = 1'b0;
        tick();
        rd_check("t6_mask", 32'h08, 32'd0);
        rd_check("t6_edge", 32'h0C, 32'd0);
        rd_check("t6_pending", 32'h04, 32'd0);
        bus_write(32'h08, 32'h4, 2'b11, 1'b0);
        rd_check("t6_mask_after", 32'h08, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
